// File: rtl/instr_encoder_if.sv
// instr_encoder_if -- request/response bundle for the instruction encoder.
//
// Request side (upstream -> encoder):
//   in_valid / in_ready      handshake, accept when both high at a rising edge
//   in_kind                  0=R-type, 1=I-type, 2=J-type, 3=illegal
//   in_op, in_aluop          opcode (I/J) and ALU op (R)
//   in_rd, in_rs, in_rt      register fields
//   in_shamt                 shift amount (R)
//   in_imm                   17-bit immediate (I)
//   in_target                27-bit jump target (J)
// Response side (encoder -> downstream):
//   out_valid / out_ready    handshake, transfer when both high at a rising edge
//   out_insn                 encoded 32-bit instruction word (oldest queued)
//
// Modports: master = the side issuing requests and consuming words,
//           slave  = the encoder.

interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_op;
    logic [4:0]  in_aluop;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_shamt;
    logic [16:0] in_imm;
    logic [26:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;

    modport master (
        output in_valid, in_kind, in_op, in_aluop, in_rd, in_rs, in_rt,
               in_shamt, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_insn
    );

    modport slave (
        input  in_valid, in_kind, in_op, in_aluop, in_rd, in_rs, in_rt,
               in_shamt, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_insn
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder -- packs decoded instruction fields into a 32-bit word and
// buffers the result in a 2-entry output FIFO.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high; empties the FIFO and clears
//                 the counter and the illegal flag
//   bus           instr_encoder_if.slave (request fields, in/out handshakes)
//   issued_count  number of words delivered downstream, wraps at 16 bits
//   err_illegal   sticky flag, set when an illegal-kind request is accepted
//
// Word formats:
//   R: {5'b0, rd, rs, rt, shamt, aluop, 2'b00}
//   I: {op, rd, rs, imm[16:0]}
//   J: {op, target[26:0]}
//   illegal: 32'h0 (NOP)

module instr_encoder (
    input  logic          clock,
    input  logic          reset,
    instr_encoder_if.slave bus,
    output logic [15:0]   issued_count,
    output logic          err_illegal
);

    typedef enum logic [1:0] {
        KIND_R       = 2'd0,
        KIND_I       = 2'd1,
        KIND_J       = 2'd2,
        KIND_ILLEGAL = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_e;

    fifo_state_e state, state_next;
    logic [31:0] head, head_next;   // oldest word, shown on out_insn
    logic [31:0] tail, tail_next;   // second word, valid only in TWO
    logic [31:0] enc_word;
    logic        accept;
    logic        transfer;
    kind_e       kind;

    assign kind     = kind_e'(bus.in_kind);
    assign accept   = bus.in_valid && bus.in_ready;
    assign transfer = bus.out_valid && bus.out_ready;

    // Field packing. Only the fields belonging to the selected kind reach
    // the word, so stale values on unused inputs cannot leak through.
    // NOTE: every signal assigned in an always_comb gets a default first;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        enc_word = '0;
        case (kind)
            KIND_R:  enc_word = {5'b00000, bus.in_rd, bus.in_rs, bus.in_rt,
                                 bus.in_shamt, bus.in_aluop, 2'b00};
            KIND_I:  enc_word = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_imm};
            KIND_J:  enc_word = {bus.in_op, bus.in_target};
            default: enc_word = '0;
        endcase
    end

    // FIFO next-state. In ONE with a simultaneous accept and transfer the
    // head leaves and the new word takes its place. TWO never accepts, so
    // a transfer there just promotes the tail.
    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    head_next  = enc_word;
                end
            end
            ONE: begin
                case ({accept, transfer})
                    2'b10: begin
                        state_next = TWO;
                        tail_next  = enc_word;
                    end
                    2'b01: begin
                        state_next = EMPTY;
                        head_next  = '0;
                    end
                    2'b11: begin
                        head_next  = enc_word;
                    end
                    default: ;
                endcase
            end
            TWO: begin
                if (transfer) begin
                    state_next = ONE;
                    head_next  = tail;
                    tail_next  = '0;
                end
            end
            default: begin
                state_next = EMPTY;
                head_next  = '0;
                tail_next  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the two FIFO entries are cleared by reset as well as the state,
    // so no word from before a reset can ever resurface on out_insn.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= EMPTY;
            head         <= '0;
            tail         <= '0;
            issued_count <= '0;
            err_illegal  <= 1'b0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            if (transfer) begin
                issued_count <= issued_count + 16'd1;
            end
            if (accept && kind == KIND_ILLEGAL) begin
                err_illegal <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_insn  = bus.out_valid ? head : 32'h0000_0000;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder -- directed bench for instr_encoder. A queue-based model
// tracks the expected FIFO contents, counter and flag; a compare process
// checks every output on each falling edge, and the directed sequence adds
// hand-computed literal expectations.

module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic [15:0] issued_count;
    logic        err_illegal;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clock        (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .issued_count (issued_count),
        .err_illegal  (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] m_q[$];
    logic [15:0] m_count;
    bit          m_err;
    bit          m_live = 1'b0;
    bit          m_acc;
    bit          m_xfer;
    logic [31:0] m_word;

    // Expected word straight from the field layout, as weighted sums.
    function automatic logic [31:0] model_word();
        int unsigned w;
        w = 0;
        case (bus.in_kind)
            2'd0: w = 32'(bus.in_rd) * 4194304 + 32'(bus.in_rs) * 131072
                    + 32'(bus.in_rt) * 4096 + 32'(bus.in_shamt) * 128
                    + 32'(bus.in_aluop) * 4;
            2'd1: w = 32'(bus.in_op) * 134217728 + 32'(bus.in_rd) * 4194304
                    + 32'(bus.in_rs) * 131072 + 32'(bus.in_imm);
            2'd2: w = 32'(bus.in_op) * 134217728 + 32'(bus.in_target);
            default: w = 0;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_count = 16'h0000;
            m_err   = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_acc  = bus.in_valid && (m_q.size() < 2);
            m_xfer = (m_q.size() > 0) && bus.out_ready;
            m_word = model_word();
            if (m_xfer) begin
                void'(m_q.pop_front());
                m_count = m_count + 16'd1;
            end
            if (m_acc) begin
                m_q.push_back(m_word);
                if (bus.in_kind == 2'd3) m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            check("cmp_in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
            check("cmp_out_insn", bus.out_insn, (m_q.size() != 0) ? m_q[0] : 32'h0);
            check("cmp_issued_count", 32'(issued_count), 32'(m_count));
            check("cmp_err_illegal", 32'(err_illegal), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [1:0] kind, input logic [4:0] op,
                       input logic [4:0] aluop, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] shamt, input logic [16:0] imm,
                       input logic [26:0] target);
        bus.in_valid  = 1'b1;
        bus.in_kind   = kind;
        bus.in_op     = op;
        bus.in_aluop  = aluop;
        bus.in_rd     = rd;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_shamt  = shamt;
        bus.in_imm    = imm;
        bus.in_target = target;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_kind   = 2'd0;
        bus.in_op     = '0;
        bus.in_aluop  = '0;
        bus.in_rd     = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_shamt  = '0;
        bus.in_imm    = '0;
        bus.in_target = '0;
        bus.out_ready = 1'b0;

        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_out_insn", bus.out_insn, 32'h0);
        check("rst_issued_count", 32'(issued_count), 32'h0);
        check("rst_err_illegal", 32'(err_illegal), 32'h0);
        reset = 1'b0;

        // R-type, with junk on in_op/imm/target that must be ignored
        bus.out_ready = 1'b1;
        req(2'd0, 5'h1F, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 17'h1FFFF, 27'h7FFFFFF);
        step();
        bus.in_valid = 1'b0;
        check("r_out_insn", bus.out_insn, 32'h0044_3000);
        check("r_out_valid", 32'(bus.out_valid), 32'h1);
        step();
        check("r_issued_count", 32'(issued_count), 32'h1);
        check("r_drained", 32'(bus.out_valid), 32'h0);

        // I-type, junk on aluop/rt/shamt/target
        req(2'd1, 5'b00101, 5'h1F, 5'd4, 5'd0, 5'h1F, 5'h1F, 17'd5, 27'h7FFFFFF);
        step();
        bus.in_valid = 1'b0;
        check("i_out_insn", bus.out_insn, 32'h2900_0005);
        step();

        // J-type, junk on everything but op/target
        req(2'd2, 5'b00001, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 17'h1FFFF, 27'h100);
        step();
        bus.in_valid = 1'b0;
        check("j_out_insn", bus.out_insn, 32'h0800_0100);
        step();
        check("j_issued_count", 32'(issued_count), 32'h3);

        // Backpressure: A, B, C back to back with out_ready low
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        req(2'd0, 5'h00, 5'd9, 5'd5, 5'd6, 5'd7, 5'd8, 17'h0, 27'h0);        // A
        step();
        check("bp_a_head", bus.out_insn, 32'h014C_7424);
        check("bp_a_in_ready", 32'(bus.in_ready), 32'h1);
        req(2'd1, 5'd2, 5'd0, 5'd3, 5'd4, 5'd0, 5'd0, 17'h1ABCD, 27'h0);     // B
        step();
        check("bp_full_in_ready", 32'(bus.in_ready), 32'h0);
        check("bp_full_head", bus.out_insn, 32'h014C_7424);
        req(2'd2, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h0, 27'h5A5A5A5);  // C
        step();
        step();
        check("bp_stall_head", bus.out_insn, 32'h014C_7424);
        check("bp_stall_in_ready", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 1'b1;
        step();
        check("bp_b_head", bus.out_insn, 32'h10C9_ABCD);
        check("bp_b_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("bp_c_head", bus.out_insn, 32'hFDA5_A5A5);
        bus.in_valid = 1'b0;
        step();
        check("bp_issued_count", 32'(issued_count), 32'h3);
        check("bp_empty", 32'(bus.out_valid), 32'h0);

        // Illegal kind followed by a legal request
        req(2'd3, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 17'h1FFFF, 27'h7FFFFFF);
        step();
        bus.in_valid = 1'b0;
        check("ill_out_insn", bus.out_insn, 32'h0);
        check("ill_out_valid", 32'(bus.out_valid), 32'h1);
        check("ill_err", 32'(err_illegal), 32'h1);
        step();
        req(2'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h0, 27'h0ABCDEF);
        step();
        bus.in_valid = 1'b0;
        check("ill_after_insn", bus.out_insn, 32'h18AB_CDEF);
        check("ill_sticky", 32'(err_illegal), 32'h1);
        step();

        // Reset while full, with in_valid held high through the reset edge
        bus.out_ready = 1'b0;
        req(2'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h0, 27'h1);
        step();
        req(2'd1, 5'd4, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 17'h2, 27'h0);
        step();
        check("rf_full_in_ready", 32'(bus.in_ready), 32'h0);
        reset = 1'b1;
        step();
        check("rf_out_valid", 32'(bus.out_valid), 32'h0);
        check("rf_in_ready", 32'(bus.in_ready), 32'h1);
        check("rf_issued_count", 32'(issued_count), 32'h0);
        check("rf_err_cleared", 32'(err_illegal), 32'h0);
        check("rf_out_insn", bus.out_insn, 32'h0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("rf_still_empty", 32'(bus.out_valid), 32'h0);

        // Counter wrap: stream one word per cycle up to 16'hFFFF, then one more
        bus.out_ready = 1'b1;
        req(2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h0, 27'h7);
        for (int i = 0; i < 70000 && m_count != 16'hFFFF; i++) begin
            step();
        end
        check("wrap_at_max", 32'(issued_count), 32'h0000_FFFF);
        step();
        check("wrap_to_zero", 32'(issued_count), 32'h0);
        bus.in_valid = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock with a synchronous, active-high reset.
REQ-002 The block SHALL provide these ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept
- in_kind  in  2  0=R-type, 1=I-type, 2=J-type, 3=illegal
- in_op  in  5  opcode for I/J-type; ignored for R-type
- in_aluop  in  5  ALU op, R-type only
- in_rd, in_rs, in_rt  in  5 each  register fields
- in_shamt  in  5  shift amount, R-type only
- in_imm  in  17  I-type immediate
- in_target  in  27  J-type target
- out_valid  out  1  instruction word present
- out_ready  in  1  downstream accepts
- out_insn  out  32  encoded instruction
- issued_count  out  16  instructions delivered
- err_illegal  out  1  sticky illegal-kind flag

Function
REQ-003 The R-type word SHALL be: [31:27]=00000 (forced), [26:22]=rd, [21:17]=rs, [16:12]=rt, [11:7]=shamt, [6:2]=aluop, [1:0]=00.
REQ-004 The I-type word SHALL be: [31:27]=in_op, [26:22]=rd, [21:17]=rs, [16:0]=imm.
REQ-005 The J-type word SHALL be: [31:27]=in_op, [26:0]=target.
REQ-006 When in_kind=3, the block SHALL enqueue 32'h00000000 (NOP) and set err_illegal on the accept edge.
REQ-007 err_illegal SHALL stay high until reset.
REQ-008 Input accept SHALL occur when in_valid and in_ready are both high at a rising edge; the encoded word is captured on that edge.
REQ-009 Output transfer SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-010 The output side SHALL be a 2-entry FIFO with state machine EMPTY, ONE and TWO; in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO.
REQ-011 FIFO state transitions SHALL be:
- EMPTY + accept -> ONE
- ONE + accept, no transfer -> TWO
- ONE + transfer, no accept -> EMPTY
- ONE + accept + transfer -> ONE, newest word moves to head
- TWO + transfer -> ONE
- any other case holds the current state
REQ-012 Latency SHALL be one cycle: a word accepted at edge N is on out_insn with out_valid=1 after edge N when the FIFO was EMPTY.
REQ-013 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-014 out_insn SHALL show the oldest entry and SHALL be 32'h0 when out_valid=0.
REQ-015 While out_valid=1 and out_ready=0, out_insn SHALL stay stable.
REQ-016 Words SHALL leave the FIFO in acceptance order; no word is dropped or duplicated.
REQ-017 issued_count SHALL increment by 1 per output transfer and wrap from 16'hFFFF to 16'h0000.
REQ-018 In TWO, in_valid SHALL be ignored (no accept), including in the cycle a transfer occurs; in_ready rises the cycle after.
REQ-019 Input fields unused by the selected kind SHALL NOT affect out_insn.

Reset
REQ-020 While reset=1 at a rising edge, the block SHALL set state to EMPTY, in_ready=1, out_valid=0, out_insn=0, issued_count=0, err_illegal=0, and clear both FIFO entries.
REQ-021 A reset asserted mid-operation SHALL discard all buffered words.
REQ-022 No accept or transfer SHALL be registered in a cycle where reset=1.

Verification
REQ-023 R-type case: kind=0, rd=1, rs=2, rt=3, shamt=0, aluop=0, in_op=5'b11111, out_ready=1 -> next cycle out_insn=32'h00443000, out_valid=1; issued_count=1 after the transfer edge.
REQ-024 I-type case: kind=1, op=5'b00101, rd=4, rs=0, imm=5 -> out_insn=32'h29000005.
REQ-025 J-type case: kind=2, op=5'b00001, target=27'h100 -> out_insn=32'h08000100.
REQ-026 Backpressure case: out_ready=0, three back-to-back requests A, B, C ->
- in_ready=0 after the second accept; C is not taken
- out_insn=A stays stable
- after out_ready=1: A, then B, then C (re-presented) appear in order; issued_count=3
REQ-027 Illegal case: kind=3 -> out_insn=32'h0; err_illegal=1 and stays 1 through later legal requests until reset.
REQ-028 Reset/wrap case: issued_count preloaded to 16'hFFFF by transfers, then one more transfer -> 16'h0000; reset with FIFO in TWO -> next cycle out_valid=0, in_ready=1, issued_count=0.
